// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: needs to represent 0..WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_sign.sv
// Sign handling for the multiplier: operand magnitudes at capture and
// conditional two's negation of the final product magnitude.
module seq_mult_sign #(
  parameter int WIDTH = 4
) (
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     a_mag,
  output logic [WIDTH-1:0]     b_mag,
  output logic                 neg,
  input  logic                 prod_neg,
  input  logic [2*WIDTH-1:0]   mag,
  output logic [2*WIDTH-1:0]   prod
);

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    a_mag = (mode && a[WIDTH-1]) ? -a : a;
    b_mag = (mode && b[WIDTH-1]) ? -b : b;
    neg   = mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    prod  = prod_neg ? -mag : mag;
  end

endmodule

// File: rtl/seq_mult_param.sv
// WIDTH x WIDTH sequential shift-add multiplier, unsigned or signed per
// operation, with a start/busy/done handshake and fixed WIDTH+1 latency.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 St,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Multiplier,
  input  logic [WIDTH-1:0]     Multiplicand,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Result
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   mcand;
  logic               neg;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               op_neg;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mag, prod;
  logic               accept, last;

  seq_mult_sign #(.WIDTH(WIDTH)) u_sign (
    .mode     (Signed),
    .a        (Multiplicand),
    .b        (Multiplier),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .neg      (op_neg),
    .prod_neg (neg),
    .mag      (mag),
    .prod     (prod)
  );

  // mag is the product magnitude as it will stand after this step's shift,
  // so Result can be loaded on the same edge that enters DONE.
  always_comb begin
    sum  = acc + {1'b0, (mplr[0] ? mcand : '0)};
    mag  = {sum, mplr[WIDTH-1:1]};
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (St) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (St) begin
          accept   = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt    <= '0;
      acc    <= '0;
      mplr   <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      Result <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      mplr   <= b_mag;
      mcand  <= a_mag;
      neg    <= op_neg;
    end else if (state == CALC) begin
      acc  <= {1'b0, sum[WIDTH:1]};
      mplr <= {sum[0], mplr[WIDTH-1:1]};
      cnt  <= cnt + CW'(1);
      if (last) Result <= prod;
    end
  end

endmodule
